// File: rtl/cargador_instrucciones_if.sv
// Bus between the program loader and its surroundings: start/count request,
// the incoming byte stream, the instruction-memory write port and status.
//
// Byte handshake: a byte is transferred on a rising clk edge where
// byte_valido and byte_listo are both 1. byte_listo depends only on the
// loader state, never on byte_valido. The producer keeps byte_dato stable
// while byte_valido is high and has not yet been accepted.
interface cargador_instrucciones_if;
    logic        iniciar;
    logic [7:0]  num_palabras;
    logic        byte_valido;
    logic [7:0]  byte_dato;
    logic        byte_listo;
    logic        escribir_habilitar;
    logic [31:0] escribir_direccion;
    logic [31:0] escribir_dato;
    logic        cargando;
    logic        listo;
    logic        error;
    logic        cpu_reset;
    logic [2:0]  estado;

    // Loader side
    modport slave (
        input  iniciar, num_palabras, byte_valido, byte_dato,
        output byte_listo, escribir_habilitar, escribir_direccion, escribir_dato,
        output cargando, listo, error, cpu_reset, estado
    );

    // Host / stream source side
    modport master (
        output iniciar, num_palabras, byte_valido, byte_dato,
        input  byte_listo, escribir_habilitar, escribir_direccion, escribir_dato,
        input  cargando, listo, error, cpu_reset, estado
    );
endinterface

// File: rtl/cargador_instrucciones.sv
// Run-time program loader: packs a byte stream into little-endian 32-bit
// words and writes them to instruction memory at byte addresses 0,4,8,...
// The core is held in reset until the requested word count is written.
// bus.estado exposes the FSM state for debug.
module cargador_instrucciones #(
    parameter int PALABRAS = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    cargador_instrucciones_if.slave  bus
);
    typedef enum logic [2:0] {
        INACTIVO  = 3'd0,
        RECIBIR   = 3'd1,
        ESCRIBIR  = 3'd2,
        TERMINADO = 3'd3,
        ERROR     = 3'd4
    } estado_t;

    localparam logic [7:0] MAX_PALABRAS = 8'(PALABRAS);

    estado_t     estado, estado_sig;
    logic [1:0]  byte_cnt;
    logic [7:0]  indice;
    logic [7:0]  num_reg;
    logic [31:0] ensamblado;
    logic [31:0] dir_reg;
    logic [31:0] dato_reg;
    logic        acepta;
    logic        arranque_ok;
    logic        ultima;

    assign acepta      = (estado == RECIBIR) && bus.byte_valido;
    assign arranque_ok = bus.iniciar && (bus.num_palabras != 8'd0) &&
                         (bus.num_palabras <= MAX_PALABRAS);
    assign ultima      = (indice == (num_reg - 8'd1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= INACTIVO;
        else       estado <= estado_sig;
    end

    // Next state and state-decoded outputs
    always_comb begin
        estado_sig             = estado;
        bus.byte_listo         = 1'b0;
        bus.escribir_habilitar = 1'b0;
        bus.cargando           = 1'b0;
        bus.listo              = 1'b0;
        bus.error              = 1'b0;
        bus.cpu_reset          = 1'b1;
        case (estado)
            INACTIVO, TERMINADO, ERROR: begin
                if (bus.iniciar) begin
                    if (bus.num_palabras == 8'd0)              estado_sig = TERMINADO;
                    else if (bus.num_palabras > MAX_PALABRAS)  estado_sig = ERROR;
                    else                                       estado_sig = RECIBIR;
                end
                if (estado == TERMINADO) begin
                    bus.listo     = 1'b1;
                    bus.cpu_reset = 1'b0;
                end
                if (estado == ERROR) bus.error = 1'b1;
            end
            RECIBIR: begin
                bus.byte_listo = 1'b1;
                bus.cargando   = 1'b1;
                if (bus.byte_valido && byte_cnt == 2'd3) estado_sig = ESCRIBIR;
            end
            ESCRIBIR: begin
                bus.escribir_habilitar = 1'b1;
                bus.cargando           = 1'b1;
                estado_sig             = ultima ? TERMINADO : RECIBIR;
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    // Byte assembly, word index and held write address/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            indice     <= 8'd0;
            num_reg    <= 8'd0;
            ensamblado <= 32'd0;
            dir_reg    <= 32'd0;
            dato_reg   <= 32'd0;
        end else begin
            case (estado)
                INACTIVO, TERMINADO, ERROR: begin
                    if (arranque_ok) begin
                        byte_cnt   <= 2'd0;
                        indice     <= 8'd0;
                        ensamblado <= 32'd0;
                        num_reg    <= bus.num_palabras;
                    end
                end
                RECIBIR: begin
                    if (acepta) begin
                        ensamblado[{byte_cnt, 3'b000} +: 8] <= bus.byte_dato;
                        byte_cnt <= byte_cnt + 2'd1;
                        // Latch the completed word so it is stable during the strobe
                        if (byte_cnt == 2'd3) begin
                            dato_reg <= {bus.byte_dato, ensamblado[23:0]};
                            dir_reg  <= {22'd0, indice, 2'b00};
                        end
                    end
                end
                ESCRIBIR: begin
                    byte_cnt <= 2'd0;
                    if (!ultima) indice <= indice + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.escribir_direccion = dir_reg;
    assign bus.escribir_dato      = dato_reg;
    assign bus.estado             = estado;
endmodule

// File: tb/tb_cargador_instrucciones.sv
// Self-checking bench for cargador_instrucciones.
module tb_cargador_instrucciones;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  // clock / reset
  always #5 clk = ~clk;

  cargador_instrucciones_if bus();

  cargador_instrucciones #(.PALABRAS(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard: every strobe must match the front of the expected queue
  always @(negedge clk) begin
    if (bus.escribir_habilitar === 1'b1) begin
      n_strobe++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got addr=%h data=%h, required no write",
                 bus.escribir_direccion, bus.escribir_dato);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.escribir_direccion, bus.escribir_dato} !== mon_e) begin
          n_err++;
          $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                   bus.escribir_direccion, bus.escribir_dato, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  // driver: request a load; caller is at a negedge
  task automatic start(input int n, input bit expect_recibir);
    bus.iniciar = 1'b1;
    bus.num_palabras = 8'(n);
    @(negedge clk);
    bus.iniciar = 1'b0;
    if (expect_recibir) begin
      n_cmp++;
      if (bus.byte_listo !== 1'b1 || bus.cargando !== 1'b1) begin
        n_err++;
        $display("FAIL start_latency got byte_listo=%b cargando=%b, required 1 1",
                 bus.byte_listo, bus.cargando);
      end
    end
  endtask

  // driver: offer one byte and hold it until accepted
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byte_valido = 1'b1;
    bus.byte_dato = b;
    while (bus.byte_listo !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_timeout got byte_listo=%b, required 1 within 50 cycles", bus.byte_listo);
    end
    @(negedge clk);
    bus.byte_valido = 1'b0;
  endtask

  // driver + model: load n random words, gaps between bytes in [gmin,gmax]
  task automatic load_words(input int n, input int gmin, input int gmax);
    logic [7:0]  b[4];
    logic [31:0] addr;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
      addr = 32'(w) * 32'd4;
      exp_q.push_back({addr, b[3], b[2], b[1], b[0]});
      for (int k = 0; k < 4; k++) begin
        send_byte(b[k]);
        if (!(w == n - 1 && k == 3)) repeat ($urandom_range(gmin, gmax)) @(negedge clk);
      end
    end
    n_cmp++;
    if (bus.escribir_habilitar !== 1'b1 || bus.escribir_direccion !== 32'(n - 1) * 32'd4) begin
      n_err++;
      $display("FAIL last_strobe got en=%b addr=%h, required en=1 addr=%h",
               bus.escribir_habilitar, bus.escribir_direccion, 32'(n - 1) * 32'd4);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.listo !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.escribir_habilitar !== 1'b0) begin
      n_err++;
      $display("FAIL end_of_load got listo=%b cpu_reset=%b en=%b, required 1 0 0",
               bus.listo, bus.cpu_reset, bus.escribir_habilitar);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.byte_listo, bus.escribir_habilitar, bus.cargando, bus.listo, bus.error, bus.cpu_reset} !== 6'b000001
        || bus.escribir_direccion !== 32'd0 || bus.escribir_dato !== 32'd0) begin
      n_err++;
      $display("FAIL reset_values got bl=%b en=%b carg=%b listo=%b err=%b cpu=%b addr=%h data=%h, required 0 0 0 0 0 1 0 0",
               bus.byte_listo, bus.escribir_habilitar, bus.cargando, bus.listo, bus.error,
               bus.cpu_reset, bus.escribir_direccion, bus.escribir_dato);
    end
  endtask

  task automatic test_single_word();
    int s0;
    s0 = n_strobe;
    start(1, 1'b1);
    exp_q.push_back({32'h0, 32'h00500093});
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
    n_cmp++;
    if (bus.escribir_habilitar !== 1'b1 || bus.escribir_dato !== 32'h00500093) begin
      n_err++;
      $display("FAIL single_word got en=%b data=%h, required en=1 data=00500093",
               bus.escribir_habilitar, bus.escribir_dato);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.listo !== 1'b1 || bus.cpu_reset !== 1'b0 || n_strobe - s0 !== 1) begin
      n_err++;
      $display("FAIL single_done got listo=%b cpu_reset=%b strobes=%0d, required 1 0 1",
               bus.listo, bus.cpu_reset, n_strobe - s0);
    end
  endtask

  task automatic test_gaps();
    int s0;
    s0 = n_strobe;
    start(3, 1'b1);
    load_words(3, 2, 2);
    n_cmp++;
    if (n_strobe - s0 !== 3 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL gaps_count got strobes=%0d pending=%0d, required 3 0", n_strobe - s0, exp_q.size());
    end
  endtask

  task automatic test_random();
    int s0, n;
    for (int r = 0; r < 4; r++) begin
      s0 = n_strobe;
      n = $urandom_range(1, 6);
      start(n, 1'b1);
      load_words(n, 0, 3);
      n_cmp++;
      if (n_strobe - s0 !== n || exp_q.size() !== 0) begin
        n_err++;
        $display("FAIL random_count got strobes=%0d pending=%0d, required %0d 0", n_strobe - s0, exp_q.size(), n);
      end
    end
  endtask

  task automatic test_bounds();
    int s0;
    s0 = n_strobe;
    start(0, 1'b0);
    n_cmp++;
    if (bus.listo !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.cargando !== 1'b0) begin
      n_err++;
      $display("FAIL zero_words got listo=%b cpu_reset=%b cargando=%b, required 1 0 0",
               bus.listo, bus.cpu_reset, bus.cargando);
    end
    repeat (3) @(negedge clk);
    start(200, 1'b0);
    n_cmp++;
    if (bus.error !== 1'b1 || bus.cpu_reset !== 1'b1 || bus.listo !== 1'b0 || bus.byte_listo !== 1'b0) begin
      n_err++;
      $display("FAIL too_many got err=%b cpu_reset=%b listo=%b bl=%b, required 1 1 0 0",
               bus.error, bus.cpu_reset, bus.listo, bus.byte_listo);
    end
    bus.byte_valido = 1'b1;
    bus.byte_dato = 8'hAA;
    repeat (4) @(negedge clk);
    bus.byte_valido = 1'b0;
    start(129, 1'b0);
    n_cmp++;
    if (bus.error !== 1'b1 || n_strobe !== s0) begin
      n_err++;
      $display("FAIL count_129 got err=%b strobes=%0d, required 1 0", bus.error, n_strobe - s0);
    end
    start(1, 1'b1);
    n_cmp++;
    if (bus.error !== 1'b0) begin
      n_err++;
      $display("FAIL error_clear got err=%b, required 0", bus.error);
    end
    load_words(1, 0, 0);
    n_cmp++;
    if (n_strobe - s0 !== 1 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL bounds_count got strobes=%0d pending=%0d, required 1 0", n_strobe - s0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    logic [7:0] b[4];
    s0 = n_strobe;
    start(2, 1'b1);
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(1, 255));
    exp_q.push_back({32'h0, b[3], b[2], b[1], b[0]});
    for (int k = 0; k < 4; k++) send_byte(b[k]);
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.byte_listo, bus.escribir_habilitar, bus.cargando, bus.listo, bus.error, bus.cpu_reset} !== 6'b000001
        || bus.escribir_direccion !== 32'd0 || bus.escribir_dato !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset got bl=%b en=%b carg=%b listo=%b err=%b cpu=%b addr=%h data=%h, required 0 0 0 0 0 1 0 0",
               bus.byte_listo, bus.escribir_habilitar, bus.cargando, bus.listo, bus.error,
               bus.cpu_reset, bus.escribir_direccion, bus.escribir_dato);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n_strobe - s0 !== 1 || exp_q.size() !== 0 || bus.cargando !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_count got strobes=%0d pending=%0d cargando=%b, required 1 0 0",
               n_strobe - s0, exp_q.size(), bus.cargando);
    end
    start(1, 1'b1);
    load_words(1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int s0;
    longint t0;
    logic [7:0] b[4];
    s0 = n_strobe;
    start(128, 1'b1);
    t0 = $time;
    load_words(128, 0, 0);
    n_cmp++;
    if (n_strobe - s0 !== 128 || exp_q.size() !== 0 || ($time - t0) !== 64'd6400) begin
      n_err++;
      $display("FAIL full_depth got strobes=%0d pending=%0d time=%0d, required 128 0 6400",
               n_strobe - s0, exp_q.size(), $time - t0);
    end
    // restart from TERMINADO, then iniciar mid-word must be ignored
    start(1, 1'b1);
    n_cmp++;
    if (bus.cpu_reset !== 1'b1 || bus.listo !== 1'b0) begin
      n_err++;
      $display("FAIL restart got cpu_reset=%b listo=%b, required 1 0", bus.cpu_reset, bus.listo);
    end
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
    exp_q.push_back({32'h0, b[3], b[2], b[1], b[0]});
    send_byte(b[0]);
    send_byte(b[1]);
    start(5, 1'b1);
    send_byte(b[2]);
    send_byte(b[3]);
    @(negedge clk);
    n_cmp++;
    if (bus.listo !== 1'b1 || exp_q.size() !== 0 || n_strobe - s0 !== 129) begin
      n_err++;
      $display("FAIL iniciar_ignored got listo=%b pending=%0d strobes=%0d, required 1 0 129",
               bus.listo, exp_q.size(), n_strobe - s0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.num_palabras = 8'd0;
    bus.byte_valido = 1'b0;
    bus.byte_dato = 8'd0;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_single_word();
    test_gaps();
    test_random();
    test_bounds();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cargador_instrucciones.md
# cargador_instrucciones

Loads a program image into `memoria_instruccion` at run time, as the write-side counterpart of its read port. Receives a byte stream over a valid/ready handshake and packs each group of 4 bytes into a little-endian 32-bit instruction. Drives one word-write per instruction at byte addresses 0, 4, 8, … (the memory indexes by address/4). Holds the processor core in reset until the requested number of words has been written.

## Interface
Parameters:
- `PALABRAS`, default 128: memory depth in words; maximum loadable count (must be ≤ 255).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; forces every output to its reset value immediately.
- `iniciar`, input, 1: start request, sampled on `clk`.
- `num_palabras`, input, 8: number of words to load; sampled on the edge where `iniciar` is accepted.
- `byte_valido`, input, 1: `byte_dato` holds a valid byte.
- `byte_dato`, input, 8: stream byte.
- `byte_listo`, output, 1: loader accepts a byte this cycle.
- `escribir_habilitar`, output, 1: one-cycle write strobe to instruction memory.
- `escribir_direccion`, output, 32: byte address of the write, always a multiple of 4.
- `escribir_dato`, output, 32: instruction word.
- `cargando`, output, 1: load in progress.
- `listo`, output, 1: load finished.
- `error`, output, 1: requested count exceeds `PALABRAS`.
- `cpu_reset`, output, 1: core reset; high unless the loader is in TERMINADO.

## Operation
- **States:** INACTIVO, RECIBIR, ESCRIBIR, TERMINADO, ERROR. Reset state is INACTIVO.
- **INACTIVO / TERMINADO / ERROR, with `iniciar`=1:**
  - If `num_palabras` = 0, go to TERMINADO with no writes.
  - If `num_palabras` > `PALABRAS`, go to ERROR.
  - Otherwise go to RECIBIR, and clear the byte counter, word index and assembly register.
- **RECIBIR:**
  - `byte_listo`=1.
  - A byte is accepted on an edge where `byte_valido` and `byte_listo` are both 1.
  - Byte k (k = 0..3) is stored in assembly bits [8k+7:8k].
  - On acceptance of byte 3, go to ESCRIBIR.
- **ESCRIBIR (exactly one cycle):**
  - `byte_listo`=0.
  - `escribir_habilitar`=1, `escribir_dato` = assembled word, `escribir_direccion` = word index × 4.
  - Next state: TERMINADO if word index = `num_palabras`−1. Otherwise increment the word index, clear the byte counter and return to RECIBIR.
- **TERMINADO:** `listo`=1, `cpu_reset`=0, `cargando`=0.
- **ERROR:** `error`=1, `cpu_reset`=1, no writes.
- **`iniciar` during RECIBIR/ESCRIBIR:** ignored.
- **`byte_valido` outside RECIBIR:** ignored; no byte is consumed.
- **Outputs by state:**
  - `cargando`=1 in RECIBIR and ESCRIBIR only.
  - `listo` is 1 only in TERMINADO; `error` is 1 only in ERROR.
  - `escribir_direccion` and `escribir_dato` hold their last value outside ESCRIBIR.
- **Word index range:** 0..`PALABRAS`−1; it never wraps past `num_palabras`−1.
- **Restart from TERMINADO:** `cpu_reset` returns to 1 on the same edge that enters RECIBIR.
- **Reset mid-load:** the partial word is discarded, no write is emitted, and the block returns to INACTIVO. Words already written stay in memory; clearing memory is the memory's own reset.

## Timing
- **Reset values:**
  - `byte_listo`=0, `escribir_habilitar`=0.
  - `escribir_direccion`=0, `escribir_dato`=0.
  - `cargando`=0, `listo`=0, `error`=0.
  - `cpu_reset`=1.
- All outputs are registered or decoded from the state register; none depends combinationally on `byte_valido`.
- **Start latency:** `iniciar` is accepted on edge N; `byte_listo`=1 from cycle N+1.
- **Write latency:** byte 3 is accepted on edge M; `escribir_habilitar`=1 during cycle M+1 only.
- **Throughput:** with `byte_valido` held at 1, one word per 5 cycles.
- **End of load:** TERMINADO is entered on the edge after the last ESCRIBIR cycle, so `listo`=1 and `cpu_reset`=0 one cycle after the final strobe.
- **Idle stream:** with `byte_valido`=0, RECIBIR waits indefinitely and keeps the byte counter.

## Test plan
- **Single word:** `num_palabras`=1, bytes 0x93,0x00,0x50,0x00 back-to-back → one strobe with addr 0x0 and data 0x00500093, then `listo`=1 and `cpu_reset`=0 one cycle later.
- **Three words with gaps:** `num_palabras`=3, `byte_valido` low for 2 cycles between bytes → strobes at 0x0, 0x4, 0x8 with correct little-endian words; strobe count is exactly 3.
- **Bounds:**
  - `num_palabras`=0 → TERMINADO with no strobe.
  - `num_palabras`=200 → `error`=1, `cpu_reset`=1, no strobe.
  - A subsequent `iniciar` with `num_palabras`=1 → normal load.
- **Asynchronous reset mid-load:** after 2 bytes of word 1, assert `reset` between clock edges → outputs reach reset values immediately with no strobe. Then reload 1 word → write at address 0x0.
- **Full depth and restart:** `num_palabras`=128 → last strobe at 0x1FC, then `listo`=1. `iniciar` in TERMINADO → `cpu_reset`=1 and `listo`=0 on the next edge. `iniciar` pulsed during RECIBIR has no effect.
